// File: rtl/aurora_block_sync_if.sv
// Sync-header bus between the lane gearbox and the block-sync controller.
// The gearbox side drives headers and receives slip requests and status.
interface aurora_block_sync_if #(
  parameter int SLIP_W = 7
);
  logic [1:0]        header_i;
  logic              header_valid_i;
  logic              slip_o;
  logic              locked_o;
  logic [1:0]        state_o;
  logic [SLIP_W-1:0] slip_cnt_o;
  logic              rot_fail_o;
  logic [7:0]        lock_loss_cnt_o;

  modport master (
    output header_i, header_valid_i,
    input  slip_o, locked_o, state_o, slip_cnt_o, rot_fail_o, lock_loss_cnt_o
  );

  modport slave (
    input  header_i, header_valid_i,
    output slip_o, locked_o, state_o, slip_cnt_o, rot_fail_o, lock_loss_cnt_o
  );
endinterface

// File: rtl/aurora_block_sync_ctrl.sv
// 64b/66b block alignment: hunts for consecutive valid sync headers, bit-slips
// the gearbox on errors and monitors the header error rate once locked.
module aurora_block_sync_ctrl #(
  parameter int LOCK_COUNT = 64,
  parameter int WIN_SIZE   = 1024,
  parameter int ERR_MAX    = 16,
  parameter int SLIP_WAIT  = 16,
  parameter int N_SLIP     = 66
) (
  input  logic                clk_rx_i,
  input  logic                rst_i,
  input  logic                enable_i,
  aurora_block_sync_if.slave  bus_if
);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(WIN_SIZE + 1);
  localparam int ERR_W  = $clog2(ERR_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int SLIP_W = $clog2(N_SLIP + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SLIP   = 2'b01,
    WAIT   = 2'b10,
    LOCKED = 2'b11
  } state_e;

  state_e            state_q;
  logic [GOOD_W-1:0] good_cnt_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic              rot_fail_q, rot_fail_d;
  logic [7:0]        lock_loss_q;
  logic              hdr_ok;

  assign hdr_ok = bus_if.header_i[1] ^ bus_if.header_i[0];

  // Slip counter value and sticky rotation flag used whenever SLIP is entered
  always_comb begin
    slip_cnt_d = slip_cnt_q + 1'b1;
    rot_fail_d = rot_fail_q;
    if (slip_cnt_q == SLIP_W'(N_SLIP - 1)) begin
      slip_cnt_d = '0;
      rot_fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk_rx_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HUNT;
      good_cnt_q  <= '0;
      win_cnt_q   <= '0;
      err_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      rot_fail_q  <= 1'b0;
      lock_loss_q <= '0;
    end else if (!enable_i) begin
      state_q    <= HUNT;
      good_cnt_q <= '0;
      win_cnt_q  <= '0;
      err_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_cnt_q <= '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (bus_if.header_valid_i) begin
            if (!hdr_ok) begin
              good_cnt_q <= '0;
              state_q    <= SLIP;
              slip_cnt_q <= slip_cnt_d;
              rot_fail_q <= rot_fail_d;
            end else if (good_cnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
              good_cnt_q <= '0;
              win_cnt_q  <= '0;
              err_cnt_q  <= '0;
              state_q    <= LOCKED;
            end else begin
              good_cnt_q <= good_cnt_q + 1'b1;
            end
          end
        end
        SLIP: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
            wait_cnt_q <= '0;
            good_cnt_q <= '0;
            state_q    <= HUNT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          // Loss of lock is checked before the window wrap so it wins a tie
          if (bus_if.header_valid_i) begin
            if (!hdr_ok && (err_cnt_q == ERR_W'(ERR_MAX - 1))) begin
              win_cnt_q  <= '0;
              err_cnt_q  <= '0;
              state_q    <= SLIP;
              slip_cnt_q <= slip_cnt_d;
              rot_fail_q <= rot_fail_d;
              if (lock_loss_q != 8'hFF) lock_loss_q <= lock_loss_q + 8'd1;
            end else if (win_cnt_q == WIN_W'(WIN_SIZE - 1)) begin
              win_cnt_q <= '0;
              err_cnt_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              if (!hdr_ok) err_cnt_q <= err_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign bus_if.slip_o          = (state_q == SLIP);
  assign bus_if.locked_o        = (state_q == LOCKED);
  assign bus_if.state_o         = state_q;
  assign bus_if.slip_cnt_o      = slip_cnt_q;
  assign bus_if.rot_fail_o      = rot_fail_q;
  assign bus_if.lock_loss_cnt_o = lock_loss_q;
endmodule

// File: tb/tb_aurora_block_sync_ctrl.sv
// Directed bench for the block-sync controller: lock, slip/wait, loss of lock,
// window boundary, rotation failure and asynchronous reset.
module tb_aurora_block_sync_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic enable;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   nslip;
  logic saw_slip;

  aurora_block_sync_if bus ();

  aurora_block_sync_ctrl dut (
    .clk_rx_i (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .bus_if   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] h, input logic v);
    bus.header_i       = h;
    bus.header_valid_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},  {30'd0, bus.state_o}, 32'd0);
    chk({tag, "_slip"},   {31'd0, bus.slip_o}, 32'd0);
    chk({tag, "_locked"}, {31'd0, bus.locked_o}, 32'd0);
    chk({tag, "_scnt"},   {25'd0, bus.slip_cnt_o}, 32'd0);
    chk({tag, "_rot"},    {31'd0, bus.rot_fail_o}, 32'd0);
    chk({tag, "_lloss"},  {24'd0, bus.lock_loss_cnt_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b1;
    bus.header_i = 2'b00;
    bus.header_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("por");
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;

    // Slip and wait: 10 good headers then an invalid one
    for (int i = 0; i < 10; i++) cyc(i[0] ? 2'b10 : 2'b01, 1'b1);
    chk("hunt_state", {30'd0, bus.state_o}, 32'd0);
    cyc(2'b11, 1'b1);
    chk("slip_state", {30'd0, bus.state_o}, 32'd1);
    chk("slip_pulse", {31'd0, bus.slip_o}, 32'd1);
    chk("slip_cnt1",  {25'd0, bus.slip_cnt_o}, 32'd1);
    cyc(2'b11, 1'b1);
    chk("wait_enter", {30'd0, bus.state_o}, 32'd2);
    saw_slip = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(2'b11, 1'b1);
      saw_slip |= bus.slip_o;
    end
    chk("wait_last", {30'd0, bus.state_o}, 32'd2);
    chk("wait_noslip", {31'd0, saw_slip}, 32'd0);
    cyc(2'b11, 1'b1);
    chk("wait_exit", {30'd0, bus.state_o}, 32'd0);
    chk("wait_scnt", {25'd0, bus.slip_cnt_o}, 32'd1);

    // Lock acquisition
    saw_slip = 1'b0;
    for (int i = 0; i < 63; i++) begin
      cyc(i[0] ? 2'b10 : 2'b01, 1'b1);
      saw_slip |= bus.slip_o;
    end
    chk("lock63", {31'd0, bus.locked_o}, 32'd0);
    cyc(2'b10, 1'b1);
    chk("lock64", {31'd0, bus.locked_o}, 32'd1);
    chk("lock_state", {30'd0, bus.state_o}, 32'd3);
    chk("lock_noslip", {31'd0, saw_slip}, 32'd0);

    // Loss of lock on 16th error in a window
    for (int i = 0; i < 15; i++) cyc(2'b00, 1'b1);
    chk("err15_locked", {31'd0, bus.locked_o}, 32'd1);
    cyc(2'b00, 1'b1);
    chk("err16_state", {30'd0, bus.state_o}, 32'd1);
    chk("err16_slip",  {31'd0, bus.slip_o}, 32'd1);
    chk("err16_lloss", {24'd0, bus.lock_loss_cnt_o}, 32'd1);
    chk("err16_scnt",  {25'd0, bus.slip_cnt_o}, 32'd2);
    for (int i = 0; i < 17; i++) cyc(2'b00, 1'b0);
    chk("relock_hunt", {30'd0, bus.state_o}, 32'd0);
    for (int i = 0; i < 64; i++) cyc(i[0] ? 2'b10 : 2'b01, 1'b1);
    chk("relock", {31'd0, bus.locked_o}, 32'd1);

    // Window boundary: errors spread across two windows, then tie on last header
    for (int i = 0; i < 15; i++) cyc(2'b11, 1'b1);
    for (int i = 0; i < 1009; i++) cyc(2'b01, 1'b1);
    chk("win1_locked", {31'd0, bus.locked_o}, 32'd1);
    for (int i = 0; i < 15; i++) cyc(2'b00, 1'b1);
    chk("win2_err15", {31'd0, bus.locked_o}, 32'd1);
    for (int i = 0; i < 1008; i++) cyc(2'b10, 1'b1);
    chk("win2_1023", {31'd0, bus.locked_o}, 32'd1);
    cyc(2'b11, 1'b1);
    chk("tie_state", {30'd0, bus.state_o}, 32'd1);
    chk("tie_lloss", {24'd0, bus.lock_loss_cnt_o}, 32'd2);
    chk("tie_scnt",  {25'd0, bus.slip_cnt_o}, 32'd3);
    for (int i = 0; i < 17; i++) cyc(2'b00, 1'b0);

    // Disable clears slip count but keeps lock-loss history
    enable = 1'b0;
    cyc(2'b00, 1'b0);
    chk("dis_state", {30'd0, bus.state_o}, 32'd0);
    chk("dis_scnt",  {25'd0, bus.slip_cnt_o}, 32'd0);
    chk("dis_lloss", {24'd0, bus.lock_loss_cnt_o}, 32'd2);
    enable = 1'b1;

    // Rotation failure after 66 slips
    nslip = 0;
    for (int i = 0; i < 2000 && nslip < 66; i++) begin
      cyc(2'b11, 1'b1);
      if (bus.slip_o) begin
        nslip++;
        if (nslip == 65) begin
          chk("rot65_scnt", {25'd0, bus.slip_cnt_o}, 32'd65);
          chk("rot65_flag", {31'd0, bus.rot_fail_o}, 32'd0);
        end
      end
    end
    chk("rot_slips", nslip, 32'd66);
    chk("rot_wrap",  {25'd0, bus.slip_cnt_o}, 32'd0);
    chk("rot_flag",  {31'd0, bus.rot_fail_o}, 32'd1);
    enable = 1'b0;
    cyc(2'b00, 1'b0);
    chk("rot_dis_flag",  {31'd0, bus.rot_fail_o}, 32'd1);
    chk("rot_dis_state", {30'd0, bus.state_o}, 32'd0);
    enable = 1'b1;
    cyc(2'b00, 1'b0);
    chk("rot_en_flag", {31'd0, bus.rot_fail_o}, 32'd1);

    // Asynchronous reset while in WAIT
    cyc(2'b11, 1'b1);
    for (int i = 0; i < 5; i++) cyc(2'b00, 1'b0);
    chk("pre_rst_state", {30'd0, bus.state_o}, 32'd2);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async");
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 63; i++) cyc(i[0] ? 2'b10 : 2'b01, 1'b1);
    chk("post_rst63", {31'd0, bus.locked_o}, 32'd0);
    cyc(2'b01, 1'b1);
    chk("post_rst64", {31'd0, bus.locked_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
